// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: default widths,
// stage-count helper, per-stage valid vector type and the full-adder cell.
package rca_pkg;

  localparam int RCA_W_DEF   = 16;
  localparam int RCA_SEG_DEF = 4;

  function automatic int rca_nstages(input int w, input int seg);
    return (w + seg - 1) / seg;
  endfunction

  localparam int RCA_NS_DEF = rca_nstages(RCA_W_DEF, RCA_SEG_DEF);

  typedef logic [RCA_NS_DEF-1:0] rca_vld_t;

  // Full-adder cell, returns {carry, sum}
  function automatic logic [1:0] rca_fa(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational N-bit ripple segment built from the rca_fa cell; also exposes
// the carry into its MSB so the top segment can derive signed overflow.
module rca_seg
  import rca_pkg::*;
#(
  parameter int N = RCA_SEG_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      {c[i+1], s[i]} = rca_fa(a[i], b[i], c[i]);
    end
  end

  assign co    = c[N];
  assign c_msb = c[N-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined W-bit add/subtract, one SEG-bit segment rippled per stage, with
// valid/ready whole-pipe stall. Define RCA_PIPE_OVF_EN to add the ovf output.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int W   = RCA_W_DEF,
  parameter int SEG = RCA_SEG_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] xr,
  input  logic [W-1:0] yr,
  input  logic         cir,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sr,
`ifdef RCA_PIPE_OVF_EN
  output logic         ovf,
`endif
  output logic         cor
);

  localparam int NS   = rca_nstages(W, SEG);
  localparam int TOPW = W - (NS - 1) * SEG;

  logic         stall;
  logic [W-1:0] ye;
  logic         ce;

  logic [W-1:0] x_q [NS];
  logic [W-1:0] x_d [NS];
  logic [W-1:0] y_q [NS];
  logic [W-1:0] y_d [NS];
  logic [W-1:0] s_q [NS];
  logic [W-1:0] s_d [NS];
  logic [NS-1:0] c_q, c_d;
  logic [NS-1:0] vld_q, vld_d;

  logic [W-1:0]  x_in [NS];
  logic [W-1:0]  y_in [NS];
  logic [W-1:0]  s_in [NS];
  logic [NS-1:0] c_in, vld_in;

  logic [SEG-1:0] seg_s [NS];
  logic [NS-1:0]  seg_co, seg_cm;

  assign stall     = vld_q[NS-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[NS-1];
  assign sr        = s_q[NS-1];
  assign cor       = c_q[NS-1];

  assign ye = sub ? ~yr : yr;
  assign ce = cir ^ sub;

  // Stage k consumes the registers of stage k-1; stage 0 consumes the ports
  always_comb begin
    x_in[0]   = xr;
    y_in[0]   = ye;
    s_in[0]   = '0;
    c_in[0]   = ce;
    vld_in[0] = in_valid;
    for (int k = 1; k < NS; k++) begin
      x_in[k]   = x_q[k-1];
      y_in[k]   = y_q[k-1];
      s_in[k]   = s_q[k-1];
      c_in[k]   = c_q[k-1];
      vld_in[k] = vld_q[k-1];
    end
  end

  for (genvar k = 0; k < NS; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int SW = (k == NS - 1) ? TOPW : SEG;
    logic [SW-1:0] s_seg;

    rca_seg #(.N(SW)) u_seg (
      .a     (x_in[k][LO +: SW]),
      .b     (y_in[k][LO +: SW]),
      .ci    (c_in[k]),
      .s     (s_seg),
      .co    (seg_co[k]),
      .c_msb (seg_cm[k])
    );

    assign seg_s[k] = SEG'(s_seg);
  end

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      x_d[k]   = x_in[k];
      y_d[k]   = y_in[k];
      c_d[k]   = seg_co[k];
      vld_d[k] = vld_in[k];
      s_d[k]   = s_in[k];
      for (int b = 0; b < W; b++) begin
        if (b / SEG == k) s_d[k][b] = seg_s[k][b % SEG];
      end
      if (stall) begin
        x_d[k]   = x_q[k];
        y_d[k]   = y_q[k];
        s_d[k]   = s_q[k];
        c_d[k]   = c_q[k];
        vld_d[k] = vld_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      vld_q <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
        s_q[k] <= s_d[k];
      end
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

`ifdef RCA_PIPE_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the MSB differs from the carry out of it
  always_comb begin
    ovf_d = seg_cm[NS-1] ^ seg_co[NS-1];
    if (stall) ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// Directed self-checking bench for rca_pipe at W=16, SEG=4 (four stages).
module tb_rca_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] xr = '0;
  logic [15:0] yr = '0;
  logic        cir = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sr;
  logic        cor;
`ifdef RCA_PIPE_OVF_EN
  logic        ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rca_pipe #(.W(16), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xr        (xr),
    .yr        (yr),
    .cir       (cir),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sr        (sr),
`ifdef RCA_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .cor       (cor)
  );

  logic [15:0] exp_s [8] = '{16'h00FF, 16'h0200, 16'h0301, 16'h0402,
                             16'h0503, 16'h0604, 16'h0705, 16'h0806};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one_beat(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic eo);
    xr = x; yr = y; cir = ci; sub = sb; in_valid = 1'b1;
    #1;
    check({tag, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, "_early"}, out_valid, 0);
    tick();
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_sr"}, sr, es);
    check({tag, "_cor"}, cor, ec);
`ifdef RCA_PIPE_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("note: %s overflow flag unknown", tag);
`endif
    tick();
    check({tag, "_drain"}, out_valid, 0);
  endtask

  initial begin
    int si, ri;
    logic [15:0] held_sr;
    logic acc, fire, seen;

    // Reset state
    tick();
    tick();
    check("rst_vld", out_valid, 0);
    check("rst_sr", sr, 0);
    check("rst_cor", cor, 0);
    check("rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single beats with exact latency
    one_beat("add",    16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    one_beat("carry",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    one_beat("sub",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    one_beat("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    one_beat("addovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    one_beat("add2",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    one_beat("subeq",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    one_beat("subci",  16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Back-to-back stream, results on consecutive cycles from cycle 4
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        xr = 16'(c * 16'h0101); yr = 16'h00FF; cir = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c + 1 >= 4 && c + 1 <= 11) begin
        check($sformatf("strm_vld%0d", c + 1), out_valid, 1);
        check($sformatf("strm_sr%0d", c + 1), sr, exp_s[c-3]);
      end else begin
        check($sformatf("strm_idle%0d", c + 1), out_valid, 0);
      end
    end

    // Back-pressure for 3 cycles mid-stream
    si = 0; ri = 0; held_sr = '0;
    for (int c = 0; c < 40 && ri < 8; c++) begin
      in_valid  = (si < 8);
      xr        = 16'(si * 16'h0101);
      yr        = 16'h00FF;
      cir       = 1'b0;
      sub       = 1'b0;
      out_ready = !(c >= 6 && c <= 8);
      #1;
      if (!out_ready) begin
        check($sformatf("bp_rdy%0d", c), in_ready, 0);
        check($sformatf("bp_vld%0d", c), out_valid, 1);
        if (c > 6) check($sformatf("bp_hold%0d", c), sr, held_sr);
        held_sr = sr;
      end
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        check($sformatf("bp_order%0d", ri), sr, (ri < 8) ? exp_s[ri] : 16'hxxxx);
        ri++;
      end
      if (acc) si++;
      tick();
    end
    check("bp_sent", si, 8);
    check("bp_recv", ri, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_empty", out_valid, 0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      xr = 16'(16'h1111 * (i + 1)); yr = 16'h1111; cir = 1'b1; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mrst_vld", out_valid, 0);
    check("mrst_sr", sr, 0);
    check("mrst_cor", cor, 0);
    check("mrst_rdy", in_ready, 1);
`ifdef RCA_PIPE_OVF_EN
    check("mrst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("mrst_lost", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
